vram_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-read-latency video RAM block between the CPU data bus and the pixel line fetcher.
- Sits inside the core next to the DVI pixel pipeline; both requesters run in the same clock domain.
- Video fetch has priority, but a streak limit guarantees CPU forward progress.
- Routes each read response back to the requester that issued it.

---
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM (1-cycle read latency) between the
// CPU data bus and the pixel line fetcher. Video wins contention, but a streak
// counter forces a CPU grant after MAX_VIDEO_STREAK consecutive video grants
// taken while the CPU was waiting. Responses return exactly one cycle after
// acceptance and are routed to the requester that issued the access.
module vram_arbiter #(
   parameter int ADDR_WIDTH       = 13,
   parameter int DATA_WIDTH       = 32,
   parameter int MAX_VIDEO_STREAK = 4
) (
   input  logic                    clock,
   input  logic                    reset,

   input  logic                    cpu_req_valid,
   output logic                    cpu_req_ready,
   input  logic                    cpu_req_write,
   input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_req_wstrb,
   output logic                    cpu_resp_valid,
   output logic [DATA_WIDTH-1:0]   cpu_resp_rdata,

   input  logic                    vid_req_valid,
   output logic                    vid_req_ready,
   input  logic [ADDR_WIDTH-1:0]   vid_req_addr,
   output logic                    vid_resp_valid,
   output logic [DATA_WIDTH-1:0]   vid_resp_rdata,

   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int         STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [3:0] STREAK_MAX = 4'(MAX_VIDEO_STREAK);

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_VID = 1'b1
   } owner_t;

   logic [3:0] streak;
   logic       at_limit;
   logic       cpu_grant;
   logic       vid_grant;
   owner_t     resp_owner;
   logic       resp_pending;

   // Grant decision: video first unless the CPU has waited out a full streak;
   // ready depends only on valid, streak and reset, never on the other ready.
   always_comb begin
      at_limit  = (streak >= STREAK_MAX);
      cpu_grant = !reset && cpu_req_valid && (!vid_req_valid || at_limit);
      vid_grant = !reset && vid_req_valid && !(cpu_req_valid && at_limit);
   end

   assign cpu_req_ready = cpu_grant;
   assign vid_req_ready = vid_grant;

   // Drive the RAM port from whichever requester holds the grant this cycle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_grant) begin
         mem_en   = 1'b1;
         mem_addr = cpu_req_addr;
         if (cpu_req_write) begin
            mem_we    = cpu_req_wstrb[STRB_WIDTH-1:0];
            mem_wdata = cpu_req_wdata;
         end
      end else if (vid_grant) begin
         mem_en   = 1'b1;
         mem_addr = vid_req_addr;
      end
   end

   // Count video grants taken while the CPU waits; any CPU grant or an idle
   // CPU restarts the count so a fresh CPU request gets the full window.
   always_ff @(posedge clock) begin
      if (reset) begin
         streak <= 4'd0;
      end else if (!cpu_req_valid || cpu_grant) begin
         streak <= 4'd0;
      end else if (vid_grant && (streak < STREAK_MAX)) begin
         streak <= streak + 4'd1;
      end
   end

   // Remember who owns the access in flight so the RAM output can be routed
   // back next cycle; writes also set pending so the CPU gets an ack.
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_pending <= 1'b0;
         resp_owner   <= OWNER_CPU;
      end else begin
         resp_pending <= cpu_grant || vid_grant;
         resp_owner   <= vid_grant ? OWNER_VID : OWNER_CPU;
      end
   end

   // Route the RAM read data to the owning requester; reset masks a response
   // that was still in flight when reset arrived.
   always_comb begin
      cpu_resp_valid = 1'b0;
      cpu_resp_rdata = '0;
      vid_resp_valid = 1'b0;
      vid_resp_rdata = '0;
      if (!reset && resp_pending) begin
         if (resp_owner == OWNER_VID) begin
            vid_resp_valid = 1'b1;
            vid_resp_rdata = mem_rdata;
         end else begin
            cpu_resp_valid = 1'b1;
            cpu_resp_rdata = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a behavioural
// byte-writable RAM with one cycle of read latency.
module tb_vram_arbiter;

   localparam int AW = 13;
   localparam int DW = 32;

   logic          clock;
   logic          reset;
   logic          cpu_req_valid;
   logic          cpu_req_ready;
   logic          cpu_req_write;
   logic [AW-1:0] cpu_req_addr;
   logic [DW-1:0] cpu_req_wdata;
   logic [3:0]    cpu_req_wstrb;
   logic          cpu_resp_valid;
   logic [DW-1:0] cpu_resp_rdata;
   logic          vid_req_valid;
   logic          vid_req_ready;
   logic [AW-1:0] vid_req_addr;
   logic          vid_resp_valid;
   logic [DW-1:0] vid_resp_rdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] ram [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   logic          prev_c;
   logic          prev_v;
   logic [DW-1:0] prev_vdata;

   vram_arbiter #(
      .ADDR_WIDTH       (AW),
      .DATA_WIDTH       (DW),
      .MAX_VIDEO_STREAK (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_req_ready  (cpu_req_ready),
      .cpu_req_write  (cpu_req_write),
      .cpu_req_addr   (cpu_req_addr),
      .cpu_req_wdata  (cpu_req_wdata),
      .cpu_req_wstrb  (cpu_req_wstrb),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_resp_rdata (cpu_resp_rdata),
      .vid_req_valid  (vid_req_valid),
      .vid_req_ready  (vid_req_ready),
      .vid_req_addr   (vid_req_addr),
      .vid_resp_valid (vid_resp_valid),
      .vid_resp_rdata (vid_resp_rdata),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Preload every word with a pattern derived from its address.
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'hC0DE0000 | 32'(i);
      mem_rdata <= '0;
   end

   // Behavioural VRAM: byte-enabled writes, registered read data.
   always @(posedge clock) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, then settle.
   task automatic applyStimulus(input logic rst, input logic cv, input logic cw,
                                input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                                input logic [3:0] cws, input logic vv,
                                input logic [AW-1:0] vaddr);
      @(negedge clock);
      reset         = rst;
      cpu_req_valid = cv;
      cpu_req_write = cw;
      cpu_req_addr  = caddr;
      cpu_req_wdata = cwd;
      cpu_req_wstrb = cws;
      vid_req_valid = vv;
      vid_req_addr  = vaddr;
      #1;
   endtask

   // One arbitration cycle with CPU reads of 0x010 (holding 0xDEADBEEF) and
   // video reads of vaddr; checks grant, RAM drive and last cycle's response.
   task automatic arbStep(input logic rst, input logic cv, input logic vv,
                          input logic [AW-1:0] vaddr, input logic exp_c,
                          input logic exp_v, input string tag);
      logic [AW-1:0] exp_addr;
      applyStimulus(rst, cv, 1'b0, 13'h010, 32'h0, 4'h0, vv, vaddr);
      exp_addr = exp_c ? 13'h010 : (exp_v ? vaddr : 13'h000);
      checkOutput({tag, ".cpu_ready"}, 32'(cpu_req_ready), 32'(exp_c));
      checkOutput({tag, ".vid_ready"}, 32'(vid_req_ready), 32'(exp_v));
      checkOutput({tag, ".mem_en"}, 32'(mem_en), 32'(exp_c | exp_v));
      checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
      checkOutput({tag, ".cpu_resp_valid"}, 32'(cpu_resp_valid), 32'(!rst && prev_c));
      checkOutput({tag, ".vid_resp_valid"}, 32'(vid_resp_valid), 32'(!rst && prev_v));
      if (!rst && prev_v) checkOutput({tag, ".vid_rdata"}, vid_resp_rdata, prev_vdata);
      if (!rst && prev_c) checkOutput({tag, ".cpu_rdata"}, cpu_resp_rdata, 32'hDEADBEEF);
      prev_c     = exp_c;
      prev_v     = exp_v;
      prev_vdata = 32'hC0DE0000 | 32'(vaddr);
   endtask

   // Directed test sequence.
   initial begin
      reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_write = 1'b0;
      cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_wstrb = '0;
      vid_req_valid = 1'b0; vid_req_addr = '0;
      prev_c = 1'b0; prev_v = 1'b0; prev_vdata = '0;

      // Reset with both requesters pushing: nothing may be granted.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, 1'b1, 13'h100);
         checkOutput("rst.cpu_ready", 32'(cpu_req_ready), 32'd0);
         checkOutput("rst.vid_ready", 32'(vid_req_ready), 32'd0);
         checkOutput("rst.mem_en", 32'(mem_en), 32'd0);
         checkOutput("rst.mem_we", 32'(mem_we), 32'd0);
         checkOutput("rst.cpu_resp_valid", 32'(cpu_resp_valid), 32'd0);
         checkOutput("rst.vid_resp_valid", 32'(vid_resp_valid), 32'd0);
      end

      // CPU write then read-back of 0x010, granted in the first free cycle.
      applyStimulus(1'b0, 1'b1, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, 1'b0, 13'h000);
      checkOutput("wr.cpu_ready", 32'(cpu_req_ready), 32'd1);
      checkOutput("wr.vid_ready", 32'(vid_req_ready), 32'd0);
      checkOutput("wr.mem_en", 32'(mem_en), 32'd1);
      checkOutput("wr.mem_we", 32'(mem_we), 32'hF);
      checkOutput("wr.mem_addr", 32'(mem_addr), 32'h010);
      checkOutput("wr.mem_wdata", mem_wdata, 32'hDEADBEEF);
      checkOutput("wr.cpu_resp_valid", 32'(cpu_resp_valid), 32'd0);

      applyStimulus(1'b0, 1'b1, 1'b0, 13'h010, 32'h0, 4'hF, 1'b0, 13'h000);
      checkOutput("rd.cpu_ready", 32'(cpu_req_ready), 32'd1);
      checkOutput("rd.mem_we", 32'(mem_we), 32'd0);
      checkOutput("wr.ack", 32'(cpu_resp_valid), 32'd1);
      checkOutput("wr.vid_resp_valid", 32'(vid_resp_valid), 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0, 1'b0, 13'h000);
      checkOutput("rd.cpu_resp_valid", 32'(cpu_resp_valid), 32'd1);
      checkOutput("rd.cpu_rdata", cpu_resp_rdata, 32'hDEADBEEF);
      checkOutput("rd.vid_resp_valid", 32'(vid_resp_valid), 32'd0);
      checkOutput("idle.mem_en", 32'(mem_en), 32'd0);

      // Byte-strobe merge: only byte 1 of 0x020 is replaced.
      applyStimulus(1'b0, 1'b1, 1'b1, 13'h020, 32'h11223344, 4'hF, 1'b0, 13'h000);
      applyStimulus(1'b0, 1'b1, 1'b1, 13'h020, 32'h0000AA00, 4'h2, 1'b0, 13'h000);
      checkOutput("strb.mem_we", 32'(mem_we), 32'h2);
      applyStimulus(1'b0, 1'b1, 1'b0, 13'h020, 32'h0, 4'h0, 1'b0, 13'h000);
      applyStimulus(1'b0, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0, 1'b0, 13'h000);
      checkOutput("strb.cpu_resp_valid", 32'(cpu_resp_valid), 32'd1);
      checkOutput("strb.cpu_rdata", cpu_resp_rdata, 32'h1122AA44);

      // Video stream of 16 back-to-back reads, data in address order.
      for (int i = 0; i < 16; i++)
         arbStep(1'b0, 1'b0, 1'b1, 13'(13'h100 + i), 1'b0, 1'b1, "vid_stream");
      arbStep(1'b0, 1'b0, 1'b0, 13'h000, 1'b0, 1'b0, "vid_tail");

      // Contention: four video grants then one CPU grant, period five.
      for (int c = 0; c < 15; c++)
         arbStep(1'b0, 1'b1, 1'b1, 13'(13'h200 + c), (c % 5) == 4, (c % 5) != 4, "contend");
      arbStep(1'b0, 1'b0, 1'b0, 13'h000, 1'b0, 1'b0, "contend_tail");

      // Reset in the cycle after a video grant, then a lone CPU request.
      for (int i = 0; i < 3; i++)
         arbStep(1'b0, 1'b1, 1'b1, 13'(13'h300 + i), 1'b0, 1'b1, "pre_rst");
      arbStep(1'b1, 1'b1, 1'b1, 13'h303, 1'b0, 1'b0, "rst_mid");
      arbStep(1'b0, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0, "post_rst_cpu");
      arbStep(1'b0, 1'b0, 1'b0, 13'h000, 1'b0, 1'b0, "post_rst_idle");

      // Reset clears a partial streak: full window of four video grants after.
      for (int i = 0; i < 3; i++)
         arbStep(1'b0, 1'b1, 1'b1, 13'(13'h310 + i), 1'b0, 1'b1, "pre_rst2");
      arbStep(1'b1, 1'b1, 1'b1, 13'h313, 1'b0, 1'b0, "rst_mid2");
      for (int c = 0; c < 5; c++)
         arbStep(1'b0, 1'b1, 1'b1, 13'(13'h320 + c), c == 4, c != 4, "post_rst_streak");
      arbStep(1'b0, 1'b0, 1'b0, 13'h000, 1'b0, 1'b0, "post_rst2_idle");

      // One-cycle CPU valid pulse while video wins: no grant, streak restarts.
      arbStep(1'b0, 1'b1, 1'b1, 13'h400, 1'b0, 1'b1, "drop_pulse");
      arbStep(1'b0, 1'b0, 1'b1, 13'h401, 1'b0, 1'b1, "drop_after");
      for (int c = 0; c < 5; c++)
         arbStep(1'b0, 1'b1, 1'b1, 13'(13'h410 + c), c == 4, c != 4, "drop_streak");
      arbStep(1'b0, 1'b0, 1'b0, 13'h000, 1'b0, 1'b0, "drop_tail");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
